load_store_unit: RTL

- Sits between the execute stage and the 64-bit word-addressed data memory.
- Accepts one load/store request at a time and drives the memory's address, writeData, MemWrite and MemRead inputs; consumes the memory's registered readData.
- Implements RV64 byte, halfword, word and doubleword accesses. Subword stores use read-modify-write; load results are sign- or zero-extended.
- Returns load_data with a done pulse to writeback.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the byte-lane selection helpers used by the align datapath.
package lsu_pkg;

    localparam int BYTES = 8;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Byte-lane mask touched by an access of size funct3[1:0] at offset a.
    function automatic logic [BYTES-1:0] lane_sel(input logic [2:0] f3, input logic [2:0] a);
        logic [BYTES-1:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01 << a;
            2'b01:   m = 8'h03 << {a[2:1], 1'b0};
            2'b10:   m = 8'h0F << {a[2], 2'b00};
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Widen a byte-lane mask to a 64-bit bit mask.
    function automatic logic [63:0] expand_mask(input logic [BYTES-1:0] b);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < BYTES; i++) begin
            m[i*8 +: 8] = {8{b[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: request legality check,
// load lane extraction with sign/zero extension, and subword store merge.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  chk_funct3,
    input  logic        chk_is_store,
    input  logic [2:0]  chk_addr_lo,
    output logic        chk_err,
    input  logic [2:0]  op_funct3,
    input  logic [2:0]  op_addr_lo,
    input  logic [63:0] rd_word,
    input  logic [63:0] merge_word,
    input  logic [63:0] store_data,
    output logic [63:0] load_val,
    output logic [63:0] merged
);

    logic        illegal_s;
    logic        misal_s;
    logic [63:0] shifted_s;
    logic [63:0] rep_s;
    logic [63:0] bitmask_s;

    // Flag illegal codes and accesses not naturally aligned to their size.
    always_comb begin
        illegal_s = (chk_funct3 == F3_ILL) || (chk_is_store && chk_funct3[2]);
        case (chk_funct3[1:0])
            2'b00:   misal_s = 1'b0;
            2'b01:   misal_s = chk_addr_lo[0];
            2'b10:   misal_s = |chk_addr_lo[1:0];
            2'b11:   misal_s = |chk_addr_lo;
            default: misal_s = 1'b0;
        endcase
        chk_err = illegal_s || misal_s;
    end

    // Bring the addressed lanes down to bit 0, then extend to 64 bits.
    always_comb begin
        shifted_s = rd_word >> {op_addr_lo, 3'b000};
        case (op_funct3)
            F3_B:    load_val = {{56{shifted_s[7]}},  shifted_s[7:0]};
            F3_H:    load_val = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_val = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    load_val = shifted_s;
            F3_BU:   load_val = {56'd0, shifted_s[7:0]};
            F3_HU:   load_val = {48'd0, shifted_s[15:0]};
            F3_WU:   load_val = {32'd0, shifted_s[31:0]};
            default: load_val = 64'd0;
        endcase
    end

    // Replicate store data across lanes and splice it in under the lane mask.
    always_comb begin
        case (op_funct3[1:0])
            2'b00:   rep_s = {8{store_data[7:0]}};
            2'b01:   rep_s = {4{store_data[15:0]}};
            2'b10:   rep_s = {2{store_data[31:0]}};
            2'b11:   rep_s = store_data;
            default: rep_s = store_data;
        endcase
        bitmask_s = expand_mask(lane_sel(op_funct3, op_addr_lo));
        merged    = (merge_word & ~bitmask_s) | (rep_s & bitmask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time, read-modify-write for subword
// stores, all outputs registered from the next-state decode.
import lsu_pkg::*;

module load_store_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_writeData,
    output logic            mem_MemWrite,
    output logic            mem_MemRead,
    input  logic [XLEN-1:0] mem_readData
);

    state_e          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [XLEN-1:0] word_q, word_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic [XLEN-1:0] mem_address_q, mem_address_d;
    logic [XLEN-1:0] mem_writeData_q, mem_writeData_d;
    logic            mem_MemWrite_q, mem_MemWrite_d;
    logic            mem_MemRead_q, mem_MemRead_d;

    logic            accept_s;
    logic            chk_err_s;
    logic [XLEN-1:0] load_val_s;
    logic [XLEN-1:0] merged_s;
    logic [XLEN-1:0] aligned_s;

    lsu_align u_align (
        .chk_funct3   (funct3),
        .chk_is_store (is_store),
        .chk_addr_lo  (addr[2:0]),
        .chk_err      (chk_err_s),
        .op_funct3    (funct3_q),
        .op_addr_lo   (addr_q[2:0]),
        .rd_word      (mem_readData),
        .merge_word   (word_q),
        .store_data   (store_data_q),
        .load_val     (load_val_s),
        .merged       (merged_s)
    );

    // Next-state decode, request latching and next values of every output.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        word_d       = word_q;
        load_data_d  = load_data_q;
        accept_s     = req_valid && req_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    is_store_d   = is_store;
                    funct3_d     = funct3;
                    addr_d       = addr;
                    store_data_d = store_data;
                    if (chk_err_s) begin
                        state_d = ST_DONE;
                    end else if (is_store && (funct3 == F3_D)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:    state_d = ST_CAP;
            ST_CAP: begin
                word_d = mem_readData;
                if (is_store_q) begin
                    state_d = ST_MERGE;
                end else begin
                    state_d     = ST_DONE;
                    load_data_d = load_val_s;
                end
            end
            ST_MERGE: state_d = ST_WR;
            ST_WR:    state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Stores and rejected requests complete with a zero load result.
        if ((state_d == ST_DONE) && (state_q != ST_CAP)) begin
            load_data_d = {XLEN{1'b0}};
        end else begin
            load_data_d = load_data_d;
        end

        // The SD fast path leaves IDLE straight into WR, so use the live address.
        if (state_q == ST_IDLE) begin
            aligned_s = {addr[XLEN-1:3], 3'b000};
        end else begin
            aligned_s = {addr_q[XLEN-1:3], 3'b000};
        end

        req_ready_d    = (state_d == ST_IDLE);
        mem_MemRead_d  = (state_d == ST_RD);
        mem_MemWrite_d = (state_d == ST_WR);
        done_d         = (state_d == ST_DONE);
        err_d          = (state_q == ST_IDLE) && accept_s && chk_err_s;

        if ((state_d == ST_RD) || (state_d == ST_CAP) || (state_d == ST_MERGE) || (state_d == ST_WR)) begin
            mem_address_d = aligned_s;
        end else begin
            mem_address_d = {XLEN{1'b0}};
        end

        if ((state_d == ST_WR) && (state_q == ST_IDLE)) begin
            mem_writeData_d = store_data;
        end else if (state_d == ST_WR) begin
            mem_writeData_d = merged_s;
        end else begin
            mem_writeData_d = {XLEN{1'b0}};
        end
    end

    // State and output registers with synchronous reset that aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            is_store_q      <= 1'b0;
            funct3_q        <= 3'b000;
            addr_q          <= {XLEN{1'b0}};
            store_data_q    <= {XLEN{1'b0}};
            word_q          <= {XLEN{1'b0}};
            load_data_q     <= {XLEN{1'b0}};
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            mem_address_q   <= {XLEN{1'b0}};
            mem_writeData_q <= {XLEN{1'b0}};
            mem_MemWrite_q  <= 1'b0;
            mem_MemRead_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_store_q      <= is_store_d;
            funct3_q        <= funct3_d;
            addr_q          <= addr_d;
            store_data_q    <= store_data_d;
            word_q          <= word_d;
            load_data_q     <= load_data_d;
            done_q          <= done_d;
            err_q           <= err_d;
            req_ready_q     <= req_ready_d;
            mem_address_q   <= mem_address_d;
            mem_writeData_q <= mem_writeData_d;
            mem_MemWrite_q  <= mem_MemWrite_d;
            mem_MemRead_q   <= mem_MemRead_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign load_data     = load_data_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_writeData_q;
    assign mem_MemWrite  = mem_MemWrite_q;
    assign mem_MemRead   = mem_MemRead_q;

endmodule
